rate_limiter: RTL and testbench

Flit-granular stream throttle that consumes the rate-limit configuration produced by the configurator and applies it to the transmit packet stream. Admits at most `num` flits per `den`-cycle window when enabled and passes traffic unthrottled when disabled. Sits between the TX packet source and the Ethernet TX path, with one registered output stage.

---
 rtl/rate_limiter.sv | 112 +++++++++++
 tb/tb_rate_limiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_limiter.sv
// rate_limiter: num/den flit throttle with one registered output stage; RATE_LIMITER_STATS_EN adds stat_throttle_cycles
package rate_limiter_pkg;
    localparam int CFG_CNT_WIDTH = 16;
    typedef struct packed {
        logic                     enable;
        logic [CFG_CNT_WIDTH-1:0] den;
        logic [CFG_CNT_WIDTH-1:0] num;
    } rate_limit_config_t;
endpackage

module rate_limiter
    import rate_limiter_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = CFG_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  rate_limit_config_t    in_conf_data,
    input  logic                  in_conf_valid,
    output logic                  in_conf_ready,
    input  logic [DATA_WIDTH-1:0] in_pkt_data,
    input  logic                  in_pkt_sop,
    input  logic                  in_pkt_eop,
    input  logic                  in_pkt_valid,
    output logic                  in_pkt_ready,
    output logic [DATA_WIDTH-1:0] out_pkt_data,
    output logic                  out_pkt_sop,
    output logic                  out_pkt_eop,
    output logic                  out_pkt_valid,
    input  logic                  out_pkt_ready
`ifdef RATE_LIMITER_STATS_EN
    ,
    output logic [31:0]           stat_throttle_cycles
`endif
);
    typedef enum logic {IDLE, IN_PKT} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    state_t               state, state_d;
    rate_limit_config_t   pend_cfg, act_cfg;
    logic                 pend_vld;
    logic [CNT_WIDTH-1:0] win_cnt, flit_cnt, win_d, flit_d;
    logic                 throttle, accept, apply, wrap;

    assign in_conf_ready = 1'b1;
    assign throttle      = act_cfg.enable && act_cfg.den != '0 && flit_cnt >= act_cfg.num;
    assign in_pkt_ready  = !rst && !throttle && (!out_pkt_valid || out_pkt_ready);
    assign accept        = in_pkt_valid && in_pkt_ready;
    assign apply         = pend_vld && state == IDLE && !accept;
    assign wrap          = act_cfg.den != '0 && win_cnt == act_cfg.den - ONE;

    // packet-boundary tracking and window/flit counter next values
    always_comb begin
        state_d = state;
        if (accept && state == IDLE && in_pkt_sop && !in_pkt_eop) state_d = IN_PKT;
        if (accept && state == IN_PKT && in_pkt_eop) state_d = IDLE;
        win_d  = (apply || wrap) ? '0 : (&win_cnt ? win_cnt : win_cnt + ONE);
        flit_d = apply ? '0 :
                 wrap ? (accept ? ONE : '0) :
                 (accept && !(&flit_cnt)) ? flit_cnt + ONE : flit_cnt;
    end

    // state, counters and config registers; a newly arriving config keeps pend_vld set
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            flit_cnt <= '0;
            pend_vld <= 1'b0;
            pend_cfg <= '0;
            act_cfg  <= '0;
        end else begin
            state    <= state_d;
            win_cnt  <= win_d;
            flit_cnt <= flit_d;
            if (apply) act_cfg <= pend_cfg;
            if (in_conf_valid) begin
                pend_cfg <= in_conf_data;
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // output register: load on accept, drop valid once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pkt_valid <= 1'b0;
            out_pkt_sop   <= 1'b0;
            out_pkt_eop   <= 1'b0;
            out_pkt_data  <= '0;
        end else if (accept) begin
            out_pkt_valid <= 1'b1;
            out_pkt_sop   <= in_pkt_sop;
            out_pkt_eop   <= in_pkt_eop;
            out_pkt_data  <= in_pkt_data;
        end else if (out_pkt_ready) begin
            out_pkt_valid <= 1'b0;
        end
    end

`ifdef RATE_LIMITER_STATS_EN
    // saturating count of cycles where traffic waits on the throttle
    always_ff @(posedge clk) begin
        if (rst || apply) stat_throttle_cycles <= '0;
        else if (in_pkt_valid && throttle && !(&stat_throttle_cycles)) stat_throttle_cycles <= stat_throttle_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_rate_limiter.sv
// tb_rate_limiter: directed checks of rate_limiter throttling, config apply and backpressure
module tb_rate_limiter;
    import rate_limiter_pkg::*;

    localparam int DW = 512;

    logic               clk = 1'b0;
    logic               rst;
    rate_limit_config_t in_conf_data;
    logic               in_conf_valid;
    logic               in_conf_ready;
    logic [DW-1:0]      in_pkt_data;
    logic               in_pkt_sop;
    logic               in_pkt_eop;
    logic               in_pkt_valid;
    logic               in_pkt_ready;
    logic [DW-1:0]      out_pkt_data;
    logic               out_pkt_sop;
    logic               out_pkt_eop;
    logic               out_pkt_valid;
    logic               out_pkt_ready;
`ifdef RATE_LIMITER_STATS_EN
    logic [31:0]        stat;
`endif

    int            total = 0;
    int            passed = 0;
    int            acc = 0;
    int            outs = 0;
    int            a0;
    int            o0;
    logic [31:0]   seq;
    logic          tog;
    logic          last_acc;
    logic [DW+1:0] exp_q[$];

    rate_limiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .in_conf_data(in_conf_data),
        .in_conf_valid(in_conf_valid),
        .in_conf_ready(in_conf_ready),
        .in_pkt_data(in_pkt_data),
        .in_pkt_sop(in_pkt_sop),
        .in_pkt_eop(in_pkt_eop),
        .in_pkt_valid(in_pkt_valid),
        .in_pkt_ready(in_pkt_ready),
        .out_pkt_data(out_pkt_data),
        .out_pkt_sop(out_pkt_sop),
        .out_pkt_eop(out_pkt_eop),
        .out_pkt_valid(out_pkt_valid),
        .out_pkt_ready(out_pkt_ready)
`ifdef RATE_LIMITER_STATS_EN
        ,
        .stat_throttle_cycles(stat)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step();
        logic [DW+1:0] e;
        if (tog) out_pkt_ready = !out_pkt_ready;
        #1;
        last_acc = in_pkt_valid && in_pkt_ready;
        if (out_pkt_valid && out_pkt_ready) begin
            outs++;
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_sop", 64'(out_pkt_sop), 64'(e[DW+1]));
                check("out_eop", 64'(out_pkt_eop), 64'(e[DW]));
                check("out_data", out_pkt_data[63:0], e[63:0]);
                check("out_data_full", 64'(out_pkt_data == e[DW-1:0]), 64'd1);
            end
        end
        if (last_acc) begin
            acc++;
            exp_q.push_back({in_pkt_sop, in_pkt_eop, in_pkt_data});
        end
        @(negedge clk);
        in_conf_valid = 1'b0;
        if (last_acc) begin
            seq++;
            in_pkt_data = {16{seq}};
        end
    endtask

    task automatic send_flit(input logic s, input logic e);
        logic got;
        in_pkt_sop   = s;
        in_pkt_eop   = e;
        in_pkt_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            got = last_acc;
        end
        check("accept_timeout", 64'(got), 64'd1);
        in_pkt_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] n, input logic [15:0] d, input logic en);
        in_conf_data.num    = n;
        in_conf_data.den    = d;
        in_conf_data.enable = en;
        in_conf_valid       = 1'b1;
    endtask

    task automatic single_flits_on();
        in_pkt_sop   = 1'b1;
        in_pkt_eop   = 1'b1;
        in_pkt_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        seq           = 32'h1000;
        in_pkt_data   = {16{seq}};
        in_pkt_sop    = 1'b0;
        in_pkt_eop    = 1'b0;
        in_pkt_valid  = 1'b0;
        in_conf_data  = '0;
        in_conf_valid = 1'b0;
        out_pkt_ready = 1'b1;
        tog           = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_pkt_ready), 64'd0);
        check("rst_conf_ready", 64'(in_conf_ready), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_pkt_valid), 64'd0);
        check("rst_out_sop", 64'(out_pkt_sop), 64'd0);
        check("rst_out_eop", 64'(out_pkt_eop), 64'd0);
        check("rst_out_data", out_pkt_data[63:0], 64'd0);
        check("post_rst_in_ready", 64'(in_pkt_ready), 64'd1);
`ifdef RATE_LIMITER_STATS_EN
        check("rst_stat", 64'(stat), 64'd0);
`endif
        @(negedge clk);

        a0 = acc;
        single_flits_on();
        step();
        check("latency_out_valid", 64'(out_pkt_valid), 64'd1);
        repeat (19) step();
        check("default_20_flits", 64'(acc - a0), 64'd20);
        in_pkt_valid = 1'b0;

        set_cfg(16'd2, 16'd8, 1'b1);
        step();
        step();
        a0 = acc;
        single_flits_on();
        repeat (2) step();
        check("rate_throttled_ready", 64'(in_pkt_ready), 64'd0);
        repeat (6) step();
        check("rate_first_window", 64'(acc - a0), 64'd2);
        repeat (56) step();
        check("rate_64_cycles", 64'(acc - a0), 64'd16);
        in_pkt_valid = 1'b0;

        set_cfg(16'd0, 16'd0, 1'b0);
        step();
        step();
        a0 = acc;
        send_flit(1'b1, 1'b0);
        set_cfg(16'd0, 16'd8, 1'b1);
        send_flit(1'b0, 1'b0);
        send_flit(1'b0, 1'b0);
        send_flit(1'b0, 1'b1);
        check("boundary_4_pass", 64'(acc - a0), 64'd4);
        step();
        a0 = acc;
        single_flits_on();
        repeat (10) step();
        check("blocked_ready", 64'(in_pkt_ready), 64'd0);
        check("blocked_no_accept", 64'(acc - a0), 64'd0);
        in_pkt_valid = 1'b0;

        set_cfg(16'd0, 16'd0, 1'b0);
        step();
        step();
        send_flit(1'b1, 1'b0);
        set_cfg(16'd1, 16'd4, 1'b1);
        send_flit(1'b0, 1'b0);
        set_cfg(16'd3, 16'd4, 1'b1);
        send_flit(1'b0, 1'b0);
        send_flit(1'b0, 1'b1);
        step();
        a0 = acc;
        single_flits_on();
        repeat (4) step();
        check("last_wins_window", 64'(acc - a0), 64'd3);
        repeat (12) step();
        check("last_wins_16", 64'(acc - a0), 64'd12);
        in_pkt_valid = 1'b0;

        set_cfg(16'd0, 16'd0, 1'b0);
        step();
        step();
        o0 = outs;
        tog = 1'b1;
        for (int i = 0; i < 12; i++) send_flit(i % 3 == 0, i % 3 == 2);
        tog = 1'b0;
        out_pkt_ready = 1'b1;
        repeat (4) step();
        check("bp_out_count", 64'(outs - o0), 64'd12);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef RATE_LIMITER_STATS_EN
        set_cfg(16'd1, 16'd4, 1'b1);
        step();
        step();
        check("stat_cleared", 64'(stat), 64'd0);
        a0 = acc;
        single_flits_on();
        repeat (40) step();
        in_pkt_valid = 1'b0;
        check("stat_30", 64'(stat), 64'd30);
        check("stat_acc_10", 64'(acc - a0), 64'd10);
`endif

        in_pkt_valid = 1'b0;
        repeat (3) step();
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        check("final_out_eq_acc", 64'(outs), 64'(acc));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
